// File: rtl/sdwide_sampler.sv
// Receive-side SD sampler: finds SD-clock edges in oversampled words and captures all lines at a programmable offset.
// Optional majority-of-three sampling when SDWIDE_SAMPLER_VOTE_EN is defined.
module sdwide_sampler #(
  parameter int NCH = 4,
  parameter int NW  = 8,
  localparam int LGNW = $clog2(NW)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic              i_wait_start,
  input  logic              i_ddr,
  input  logic [LGNW-1:0]   i_shift,
  input  logic [NW-1:0]     i_ck_wide,
  input  logic [NCH*NW-1:0] i_rx_wide,
  output logic [1:0]        o_count,
  output logic [2*NCH-1:0]  o_data,
  output logic              o_started,
  output logic              o_err
);
  localparam int TW = 2*NW + 1;
  localparam int IW = $clog2(TW);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_t;
  state_t state;

  logic [NW-1:0]     ck_p0, ck_p1;
  logic              ck_last;
  logic [NCH*NW-1:0] rx_p0, rx_p1;
  logic [NCH-1:0]    rx_last;
  logic              vld_p0, vld_p1;
  logic              wait_p0, wait_p1;

  // Stage p0 holds the look-ahead word, p1 the word under evaluation, *_last the tail of the one before.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ck_p0   <= '0;
      ck_p1   <= '0;
      ck_last <= 1'b0;
      rx_p0   <= '0;
      rx_p1   <= '0;
      rx_last <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      wait_p0 <= 1'b0;
      wait_p1 <= 1'b0;
    end else begin
      ck_p0   <= i_ck_wide;
      ck_p1   <= ck_p0;
      ck_last <= ck_p1[0];
      rx_p0   <= i_rx_wide;
      rx_p1   <= rx_p0;
      for (int c = 0; c < NCH; c++) rx_last[c] <= rx_p1[c*NW];
      vld_p0  <= i_en;
      vld_p1  <= vld_p0;
      wait_p0 <= i_wait_start;
      wait_p1 <= wait_p0;
    end
  end

  // Timeline bit 2*NW-1-t holds time t of the word under evaluation (t=-1 is the previous word's tail).
  function automatic logic pick(input logic [TW-1:0] tl, input int idx);
`ifdef SDWIDE_SAMPLER_VOTE_EN
    logic a, b, c;
    a = tl[IW'(idx + 1)];
    b = tl[IW'(idx)];
    c = tl[IW'(idx - 1)];
    return (a & b) | (a & c) | (b & c);
`else
    return tl[IW'(idx)];
`endif
  endfunction

  logic [NW:0] ck_tl;
  logic [1:0]  n_edge;
  int          t_first, t_second;

  assign ck_tl = {ck_last, ck_p1};

  always_comb begin
    n_edge   = '0;
    t_first  = 0;
    t_second = 0;
    for (int t = 0; t < NW; t++) begin
      if ((ck_tl[NW-1-t] & ~ck_tl[NW-t]) | (i_ddr & ~ck_tl[NW-1-t] & ck_tl[NW-t])) begin
        if (n_edge == 2'd0)      t_first  = t;
        else if (n_edge == 2'd1) t_second = t;
        if (n_edge != 2'd3) n_edge = n_edge + 2'd1;
      end
    end
  end

  logic [NCH-1:0] vec_a, vec_b;

  always_comb begin
    vec_a = '0;
    vec_b = '0;
    for (int c = 0; c < NCH; c++) begin
      vec_a[c] = pick({rx_last[c], rx_p1[c*NW +: NW], rx_p0[c*NW +: NW]},
                      2*NW - 1 - t_first - int'(i_shift));
      vec_b[c] = pick({rx_last[c], rx_p1[c*NW +: NW], rx_p0[c*NW +: NW]},
                      2*NW - 1 - t_second - int'(i_shift));
    end
  end

  logic [1:0]       n_cap, wait_cnt;
  logic [2*NCH-1:0] cap_data, wait_data;
  logic             start_hit;

  // A start bit may be either captured vector; whatever precedes it in the word is discarded.
  always_comb begin
    n_cap     = (n_edge == 2'd3) ? 2'd2 : n_edge;
    cap_data  = '0;
    wait_cnt  = '0;
    wait_data = '0;
    start_hit = 1'b0;
    case (n_cap)
      2'd1:    cap_data = {vec_a, {NCH{1'b0}}};
      2'd2:    cap_data = {vec_a, vec_b};
      default: cap_data = '0;
    endcase
    if (n_cap != 2'd0 && !vec_a[0]) begin
      start_hit = 1'b1;
      wait_cnt  = n_cap;
      wait_data = cap_data;
    end else if (n_cap == 2'd2 && !vec_b[0]) begin
      start_hit = 1'b1;
      wait_cnt  = 2'd1;
      wait_data = {vec_b, {NCH{1'b0}}};
    end
  end

  // Output stage: enable carried with the word drives the capture state machine.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      o_count   <= '0;
      o_data    <= '0;
      o_started <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_count <= '0;
      o_data  <= '0;
      if (!vld_p1) begin
        state     <= S_IDLE;
        o_started <= 1'b0;
        o_err     <= 1'b0;
      end else begin
        if (n_edge == 2'd3) o_err <= 1'b1;
        case (state)
          S_IDLE: begin
            if (wait_p1) begin
              state     <= S_WAIT;
              o_started <= 1'b0;
            end else begin
              state     <= S_ACTIVE;
              o_started <= 1'b1;
              o_count   <= n_cap;
              o_data    <= cap_data;
            end
          end
          S_WAIT: begin
            if (start_hit) begin
              state     <= S_ACTIVE;
              o_started <= 1'b1;
              o_count   <= wait_cnt;
              o_data    <= wait_data;
            end
          end
          S_ACTIVE: begin
            o_count <= n_cap;
            o_data  <= cap_data;
          end
          default: begin
            state     <= S_IDLE;
            o_started <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
